// File: rtl/abnormality_alarm_scheduler.sv
// Abnormality alarm scheduler.
// Each of the five raw flags is debounced by a saturating persistence counter.
// A qualified flag sets a sticky pending bit. A small FSM presents one pending
// alarm at a time, in fixed priority order, and escalates it if nobody
// acknowledges it in time.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no alarm shown; first cycle with pending latches a source,
//            | next cycle enters PRESENT
// PRESENT    | alarm shown at level 1, wait timer running
// ESCALATED  | alarm shown at level 2 with escalate, waiting for ack
// CLEAR      | one quiet cycle after an ack, then IDLE
module abnormality_alarm_scheduler #(
  parameter int PERSIST = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] abnormalityVector,
  input  logic       ack,
  output logic       alarmValid,
  output logic [2:0] alarmCode,
  output logic [1:0] alarmLevel,
  output logic       escalate,
  output logic [4:0] pendingVector
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESENT   = 2'd1,
    ST_ESCALATED = 2'd2,
    ST_CLEAR     = 2'd3
  } state_t;

  localparam logic [3:0] PERSIST_M1 = 4'(PERSIST - 1);
  localparam logic [7:0] TIMEOUT_M2 = 8'(TIMEOUT - 2);

  state_t          state_q;
  logic [2:0]      src_q;
  logic [7:0]      timer_q;
  logic            valid_q;
  logic [2:0]      code_q;
  logic [1:0]      level_q;
  logic            esc_q;

  logic [4:0][3:0] cnt_q, cnt_d;
  logic [4:0]      armed_q, armed_d;
  logic [4:0]      pending_q, pending_d;
  logic [4:0]      qual;
  logic [4:0]      clr_mask;
  logic            ack_live;

  // Highest-priority pending source as an alarm code:
  // fall > pressure > nervous > blood > temperature.
  function automatic logic [2:0] pick_src(input logic [4:0] p);
    if (p[2])      return 3'd3;
    else if (p[4]) return 3'd1;
    else if (p[0]) return 3'd5;
    else if (p[3]) return 3'd2;
    else if (p[1]) return 3'd4;
    else           return 3'd0;
  endfunction

  // Alarm code back to its pending-bit position.
  function automatic logic [4:0] code_mask(input logic [2:0] c);
    case (c)
      3'd1:    return 5'b10000;
      3'd2:    return 5'b01000;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b00010;
      3'd5:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  // Persistence counters, arming, and pending set/clear. An ack-clear
  // beats a same-edge qualification of the presented source.
  always_comb begin
    ack_live = ack && (state_q == ST_PRESENT || state_q == ST_ESCALATED);
    clr_mask = ack_live ? code_mask(src_q) : 5'b00000;
    for (int i = 0; i < 5; i++) begin
      qual[i]    = abnormalityVector[i] && (cnt_q[i] == PERSIST_M1) && armed_q[i];
      cnt_d[i]   = abnormalityVector[i] ? ((cnt_q[i] == 4'hF) ? 4'hF : cnt_q[i] + 4'd1) : 4'd0;
      armed_d[i] = !abnormalityVector[i] || (armed_q[i] && !qual[i]);
    end
    pending_d = (pending_q | qual) & ~clr_mask;
  end

  // Source-side registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      armed_q   <= 5'b11111;
      pending_q <= 5'b00000;
    end else begin
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      pending_q <= pending_d;
    end
  end

  // Presentation FSM with registered outputs; src_q != 0 in IDLE means a
  // source has been latched and PRESENT follows on the next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= 3'd0;
      timer_q <= 8'd0;
      valid_q <= 1'b0;
      code_q  <= 3'd0;
      level_q <= 2'd0;
      esc_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (src_q != 3'd0) begin
            state_q <= ST_PRESENT;
            timer_q <= 8'd0;
            valid_q <= 1'b1;
            code_q  <= src_q;
            level_q <= 2'd1;
          end else if (pending_q != 5'b00000) begin
            src_q <= pick_src(pending_q);
          end
        end
        ST_PRESENT: begin
          if (ack) begin
            state_q <= ST_CLEAR;
            src_q   <= 3'd0;
            valid_q <= 1'b0;
            code_q  <= 3'd0;
            level_q <= 2'd0;
          end else begin
            timer_q <= timer_q + 8'd1;
            if (timer_q == TIMEOUT_M2) begin
              state_q <= ST_ESCALATED;
              level_q <= 2'd2;
              esc_q   <= 1'b1;
            end
          end
        end
        ST_ESCALATED: begin
          if (ack) begin
            state_q <= ST_CLEAR;
            src_q   <= 3'd0;
            valid_q <= 1'b0;
            code_q  <= 3'd0;
            level_q <= 2'd0;
            esc_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign alarmValid    = valid_q;
  assign alarmCode     = code_q;
  assign alarmLevel    = level_q;
  assign escalate      = esc_q;
  assign pendingVector = pending_q;

endmodule

// File: tb/tb_abnormality_alarm_scheduler.sv
// Directed bench for abnormality_alarm_scheduler (PERSIST=4, TIMEOUT=16).
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// so every expectation describes the state right after the edge just taken.
module tb_abnormality_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] flags;
  logic       ack;
  logic       valid;
  logic [2:0] code;
  logic [1:0] level;
  logic       esc;
  logic [4:0] pend;

  int tests = 0;
  int fails = 0;

  abnormality_alarm_scheduler #(.PERSIST(4), .TIMEOUT(16)) dut (
    .clock(clk),
    .reset(rst),
    .abnormalityVector(flags),
    .ack(ack),
    .alarmValid(valid),
    .alarmCode(code),
    .alarmLevel(level),
    .escalate(esc),
    .pendingVector(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [4:0] f;
    logic       a;
    logic       ev;
    logic [2:0] ec;
    logic [1:0] el;
    logic       ee;
    logic [4:0] ep;
  } vec_t;

  vec_t vecs[20];

  task automatic step(input logic r, input logic [4:0] f, input logic a);
    rst   = r;
    flags = f;
    ack   = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ev, input logic [2:0] ec,
                     input logic [1:0] el, input logic ee, input logic [4:0] ep);
    tests++;
    if (valid !== ev || code !== ec || level !== el || esc !== ee || pend !== ep) begin
      fails++;
      $display("FAIL %s: got valid=%b code=%0d level=%0d esc=%b pend=%b, want valid=%b code=%0d level=%0d esc=%b pend=%b",
               name, valid, code, level, esc, pend, ev, ec, el, ee, ep);
    end
  endtask

  initial begin
    rst = 1'b1; flags = 5'b0; ack = 1'b0;

    // reset, short fall pulse, pressure alarm with ack and no re-alarm
    vecs[0]  = '{1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[1]  = '{1'b1, 5'b11111, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[2]  = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[3]  = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[4]  = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[5]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[6]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[7]  = '{1'b0, 5'b10000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[8]  = '{1'b0, 5'b10000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[9]  = '{1'b0, 5'b10000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[10] = '{1'b0, 5'b10000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b10000};
    vecs[11] = '{1'b0, 5'b10000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b10000};
    vecs[12] = '{1'b0, 5'b10000, 1'b0, 1'b1, 3'd1, 2'd1, 1'b0, 5'b10000};
    vecs[13] = '{1'b0, 5'b10000, 1'b0, 1'b1, 3'd1, 2'd1, 1'b0, 5'b10000};
    vecs[14] = '{1'b0, 5'b10000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[15] = '{1'b0, 5'b10000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[16] = '{1'b0, 5'b10000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[17] = '{1'b0, 5'b10000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[18] = '{1'b0, 5'b10000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};
    vecs[19] = '{1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000};

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].r, vecs[i].f, vecs[i].a);
      chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].el, vecs[i].ee, vecs[i].ep);
    end

    // temperature presented; blood then fall qualify but do not preempt
    for (int i = 0; i < 4; i++) step(1'b0, 5'b00010, 1'b0);
    chk("tmp_qual", 1'b0, 3'd0, 2'd0, 1'b0, 5'b00010);
    step(1'b0, 5'b00010, 1'b0);
    chk("tmp_latch", 1'b0, 3'd0, 2'd0, 1'b0, 5'b00010);
    step(1'b0, 5'b00010, 1'b0);
    chk("tmp_present", 1'b1, 3'd4, 2'd1, 1'b0, 5'b00010);
    for (int i = 0; i < 4; i++) step(1'b0, 5'b01010, 1'b0);
    chk("blood_pending", 1'b1, 3'd4, 2'd1, 1'b0, 5'b01010);
    for (int i = 0; i < 4; i++) step(1'b0, 5'b01110, 1'b0);
    chk("no_preempt", 1'b1, 3'd4, 2'd1, 1'b0, 5'b01110);
    step(1'b0, 5'b00000, 1'b1);
    chk("tmp_clear", 1'b0, 3'd0, 2'd0, 1'b0, 5'b01100);
    for (int i = 0; i < 3; i++) step(1'b0, 5'b00000, 1'b0);
    chk("fall_next", 1'b1, 3'd3, 2'd1, 1'b0, 5'b01100);
    step(1'b0, 5'b00000, 1'b1);
    chk("fall_clear", 1'b0, 3'd0, 2'd0, 1'b0, 5'b01000);
    for (int i = 0; i < 3; i++) step(1'b0, 5'b00000, 1'b0);
    chk("blood_next", 1'b1, 3'd2, 2'd1, 1'b0, 5'b01000);
    step(1'b0, 5'b00000, 1'b1);
    chk("blood_clear", 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000);
    step(1'b0, 5'b00000, 1'b0);

    // nervous escalates on the 16th alarmValid cycle; re-qualify on ack edge
    for (int i = 0; i < 4; i++) step(1'b0, 5'b00001, 1'b0);
    chk("nrv_qual", 1'b0, 3'd0, 2'd0, 1'b0, 5'b00001);
    step(1'b0, 5'b00000, 1'b0);
    step(1'b0, 5'b00000, 1'b0);
    chk("nrv_cycle1", 1'b1, 3'd5, 2'd1, 1'b0, 5'b00001);
    for (int k = 2; k <= 15; k++) begin
      step(1'b0, 5'b00000, 1'b0);
      chk($sformatf("nrv_cycle%0d", k), 1'b1, 3'd5, 2'd1, 1'b0, 5'b00001);
    end
    step(1'b0, 5'b00000, 1'b0);
    chk("nrv_cycle16_esc", 1'b1, 3'd5, 2'd2, 1'b1, 5'b00001);
    for (int i = 0; i < 3; i++) step(1'b0, 5'b00001, 1'b0);
    chk("nrv_hold", 1'b1, 3'd5, 2'd2, 1'b1, 5'b00001);
    step(1'b0, 5'b00001, 1'b1);
    chk("ack_vs_requal", 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000);
    step(1'b0, 5'b00000, 1'b0);
    chk("nrv_idle", 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000);

    // reset during ESCALATED with fall presented and temperature pending
    for (int i = 0; i < 4; i++) step(1'b0, 5'b00100, 1'b0);
    step(1'b0, 5'b00100, 1'b0);
    step(1'b0, 5'b00100, 1'b0);
    chk("fall_present", 1'b1, 3'd3, 2'd1, 1'b0, 5'b00100);
    for (int i = 0; i < 15; i++) step(1'b0, 5'b00110, 1'b0);
    chk("fall_escalated", 1'b1, 3'd3, 2'd2, 1'b1, 5'b00110);
    step(1'b1, 5'b00110, 1'b0);
    chk("reset_mid_esc", 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000);
    for (int i = 0; i < 3; i++) step(1'b0, 5'b00100, 1'b0);
    chk("requal_early", 1'b0, 3'd0, 2'd0, 1'b0, 5'b00000);
    step(1'b0, 5'b00100, 1'b0);
    chk("requal", 1'b0, 3'd0, 2'd0, 1'b0, 5'b00100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
